uart_sender: RTL

UART_SENDER -- requirements
Module: uart_sender

---
 rtl/uart_sender.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_sender.sv
// 8N1 UART transmitter with a small transmit FIFO.
// Frames run back-to-back with no idle gap while bytes are queued.
module uart_sender #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       UART_TX
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   OCC_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   occ;
  logic          wr_en, pop;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    sh, sh_n;
  logic          tx, tx_n;
  logic          bit_last;

  assign tx_full  = (occ == OCC_FULL);
  assign wr_en    = tx_wr & ~tx_full;
  assign tx_busy  = (state != IDLE) || (occ != '0);
  assign UART_TX  = tx;
  assign bit_last = (cnt == CNT_LAST);

  always_ff @(posedge sysclk) begin
    if (wr_en) mem[wr_ptr] <= tx_data;
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (occ != '0) begin
          pop     = 1'b1;
          sh_n    = mem[rd_ptr];
          tx_n    = 1'b0;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_last) begin
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = sh[0];
          sh_n    = {1'b0, sh[7:1]};
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = sh[0];
            sh_n  = {1'b0, sh[7:1]};
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_last) begin
          cnt_n = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (occ != '0) begin
            pop     = 1'b1;
            sh_n    = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
